// File: rtl/half_res_video_source.sv
// SVGA timing generator that streams a 400x300 luma frame buffer pixel-doubled to 800x600,
// with frame-aligned double-buffer selection and read-latency-matched sync/count outputs.
module half_res_video_source #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter logic        SYNC_POL = 1'b1,
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              fb_sel,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic [10:0]       hcount,
    output logic [10:0]       vcount,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [7:0]        Y,
    output logic              frame_start
);

    localparam int unsigned CW      = 11;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DLY     = RD_LAT + 1;
    localparam int unsigned HALF_W  = H_ACTIVE / 2;

    logic [CW-1:0]     h_q, h_d, v_q, v_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_c;
    logic              h_last_c, v_last_c, vis_c, hs_c, vs_c, fs_c;

    logic [DLY*CW-1:0] h_dl_q, v_dl_q;
    logic [DLY-1:0]    vis_dl_q, hs_dl_q, vs_dl_q, fs_dl_q;

    logic              rd_en_q, fb_sel_q, swap_ack_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [CW-1:0]     hcount_q, vcount_q;
    logic              hsync_q, vsync_q, de_q, frame_start_q;
    logic [7:0]        y_q;

    // Raster counters, visibility/sync decode and half-resolution row base.
    always_comb begin
        h_last_c   = (h_q == CW'(H_TOTAL - 1));
        v_last_c   = (v_q == CW'(V_TOTAL - 1));
        h_d        = h_last_c ? '0 : h_q + CW'(1);
        v_d        = v_q;
        if (h_last_c) begin
            v_d = v_last_c ? '0 : v_q + CW'(1);
        end
        vis_c      = (h_q < CW'(H_ACTIVE)) && (v_q < CW'(V_ACTIVE));
        hs_c       = (h_q >= CW'(H_ACTIVE + H_FP)) && (h_q < CW'(H_ACTIVE + H_FP + H_SYNC));
        vs_c       = (v_q >= CW'(V_ACTIVE + V_FP)) && (v_q < CW'(V_ACTIVE + V_FP + V_SYNC));
        fs_c       = (h_q == '0) && (v_q == '0);
        addr_c     = row_base_q + ADDR_W'(h_q >> 1);
        row_base_d = row_base_q;
        if (h_last_c && v_last_c) begin
            row_base_d = '0;
        end else if (h_last_c && v_q[0] && (v_q < CW'(V_ACTIVE))) begin
            // Odd visible line done: the next pair of output lines reads the next stored row.
            row_base_d = row_base_q + ADDR_W'(HALF_W);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q           <= '0;
            v_q           <= '0;
            row_base_q    <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            fb_sel_q      <= 1'b0;
            swap_ack_q    <= 1'b0;
            h_dl_q        <= '0;
            v_dl_q        <= '0;
            vis_dl_q      <= '0;
            hs_dl_q       <= '0;
            vs_dl_q       <= '0;
            fs_dl_q       <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            row_base_q <= row_base_d;
            rd_en_q    <= vis_c;
            rd_addr_q  <= vis_c ? addr_c : '0;

            // Buffer swap only on the last internal cycle of a frame.
            swap_ack_q <= h_last_c && v_last_c && swap_req;
            if (h_last_c && v_last_c && swap_req) begin
                fb_sel_q <= ~fb_sel_q;
            end

            h_dl_q   <= {h_dl_q[(DLY-1)*CW-1:0], h_q};
            v_dl_q   <= {v_dl_q[(DLY-1)*CW-1:0], v_q};
            vis_dl_q <= {vis_dl_q[DLY-2:0], vis_c};
            hs_dl_q  <= {hs_dl_q[DLY-2:0], hs_c};
            vs_dl_q  <= {vs_dl_q[DLY-2:0], vs_c};
            fs_dl_q  <= {fs_dl_q[DLY-2:0], fs_c};

            hcount_q      <= h_dl_q[DLY*CW-1 -: CW];
            vcount_q      <= v_dl_q[DLY*CW-1 -: CW];
            de_q          <= vis_dl_q[DLY-1];
            hsync_q       <= hs_dl_q[DLY-1] ? SYNC_POL : ~SYNC_POL;
            vsync_q       <= vs_dl_q[DLY-1] ? SYNC_POL : ~SYNC_POL;
            y_q           <= vis_dl_q[DLY-1] ? rd_data : 8'd0;
            frame_start_q <= fs_dl_q[DLY-1];
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign fb_sel      = fb_sel_q;
    assign swap_ack    = swap_ack_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign Y           = y_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_half_res_video_source.sv
// Directed bench: default SVGA instance for line/address checks, a shrunken-raster
// instance (RD_LAT=2, active-low sync) for frame, swap and mid-frame reset checks.
module tb_half_res_video_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Default-parameter instance
    logic        rst, rd_en, fb_sel, swap_req, swap_ack, hsync, vsync, de, frame_start;
    logic [16:0] rd_addr;
    logic [7:0]  rd_data, y;
    logic [10:0] hcount, vcount;
    logic        const_mode;

    half_res_video_source dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .fb_sel(fb_sel), .swap_req(swap_req), .swap_ack(swap_ack),
        .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .de(de), .Y(y), .frame_start(frame_start)
    );

    always_ff @(posedge clk) rd_data <= const_mode ? 8'hAA : rd_addr[7:0];

    // Small raster: H_TOTAL=24, V_TOTAL=12, frame = 288 cycles, latency 4
    logic        s_rst, s_rd_en, s_fb_sel, s_swap_req, s_swap_ack, s_hsync, s_vsync, s_de, s_frame_start;
    logic [16:0] s_rd_addr;
    logic [7:0]  s_rd_data, s_y;
    logic [8:0]  s_m1;
    logic [10:0] s_hcount, s_vcount;

    half_res_video_source #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .ADDR_W(17), .RD_LAT(2)
    ) dut_s (
        .clk(clk), .rst(s_rst), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .fb_sel(s_fb_sel), .swap_req(s_swap_req), .swap_ack(s_swap_ack),
        .hcount(s_hcount), .vcount(s_vcount), .hsync(s_hsync), .vsync(s_vsync),
        .de(s_de), .Y(s_y), .frame_start(s_frame_start)
    );

    // Two-cycle memory; buffer 1 is distinguished by bit 7 flipped.
    always_ff @(posedge clk) begin
        s_m1      <= {s_fb_sel, s_rd_addr[7:0]};
        s_rd_data <= s_m1[7:0] ^ {s_m1[8], 7'd0};
    end

    logic [7:0]  line0 [800];
    logic [31:0] y4;

    initial begin
        int de_cnt, hs_cnt, hs_first, hs_last, bady, vs_seen, diff;
        int fb_err, ack_cnt, ack_bad, fs_cnt, fs_first, fs_second;
        int sde_cnt, svs_cnt, shs_cnt, svs_first, max_addr, addr_bad;
        logic exp_fb, found;

        rst = 1'b0; s_rst = 1'b0; swap_req = 1'b0; s_swap_req = 1'b0; const_mode = 1'b1;
        step(3);
        check("rst_de", 32'(de), 32'd0);
        check("rst_sync", 32'({hsync, vsync}), 32'd0);
        check("rst_cnt", 32'({hcount, vcount}), 32'd0);
        check("rst_rd", 32'({rd_en, rd_addr}), 32'd0);
        check("rst_misc", 32'({fb_sel, swap_ack, frame_start, y}), 32'd0);
        check("rst_s_sync", 32'({s_hsync, s_vsync}), 32'd3);

        rst = 1'b1;
        step(1);
        check("n1_dark", 32'({de, frame_start, y, hsync}), 32'd0);
        check("n1_rd", 32'({rd_en, rd_addr}), 32'h20000);
        step(1);
        check("n2_dark", 32'({de, frame_start}), 32'd0);
        step(1);
        check("first_px", 32'({de, frame_start, hcount, vcount, y}),
              {1'b1, 1'b1, 11'd0, 11'd0, 8'hAA});
        const_mode = 1'b0;

        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; bady = 0; vs_seen = 0;
        for (int i = 0; i < 1056; i++) begin
            if (de) de_cnt++;
            else if (y != 8'd0) bady++;
            if (hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(hcount);
                hs_last = int'(hcount);
            end
            if (vsync) vs_seen++;
            if (hcount < 11'd800) line0[hcount] = y;
            if (i == 1055) check("line_end", 32'({hcount, vcount}), 32'({11'd1055, 11'd0}));
            step(1);
        end
        check("wrap", 32'({hcount, vcount}), 32'({11'd0, 11'd1}));
        check("de_cnt", 32'(de_cnt), 32'd800);
        check("hs_cnt", 32'(hs_cnt), 32'd128);
        check("hs_first", 32'(hs_first), 32'd840);
        check("hs_last", 32'(hs_last), 32'd967);
        check("y_blank", 32'(bady), 32'd0);
        check("vs_line0", 32'(vs_seen), 32'd0);

        diff = 0; y4 = '0;
        for (int i = 0; i < 1056; i++) begin
            if (hcount >= 11'd2 && hcount < 11'd800 && y != line0[hcount]) diff++;
            if (hcount < 11'd4) y4 = {y4[23:0], y};
            step(1);
        end
        check("line_dup", 32'(diff), 32'd0);
        check("addr_seq", y4, 32'h00000101);
        step(1061);
        check("px_5_3", 32'({hcount, vcount, y}), 32'({11'd5, 11'd3, 8'h92}));
        rst = 1'b0;

        fb_err = 0; ack_cnt = 0; ack_bad = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
        sde_cnt = 0; svs_cnt = 0; shs_cnt = 0; svs_first = -1; max_addr = 0; addr_bad = 0;
        s_rst = 1'b1;
        for (int n = 1; n <= 900; n++) begin
            step(1);
            exp_fb = (n >= 288 && n < 576) || n >= 864;
            if (s_fb_sel !== exp_fb) fb_err++;
            if (s_swap_ack) begin
                ack_cnt++;
                if (n != 288 && n != 576 && n != 864) ack_bad++;
            end
            if (s_frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
            if (n >= 4 && n < 292) begin
                if (s_de) sde_cnt++;
                if (!s_hsync) shs_cnt++;
                if (!s_vsync) begin
                    svs_cnt++;
                    if (svs_first < 0) svs_first = int'(s_vcount);
                end
            end
            if (s_rd_en && int'(s_rd_addr) > max_addr) max_addr = int'(s_rd_addr);
            if (!s_rd_en && s_rd_addr != 17'd0) addr_bad++;
            if (n == 81)  check("s_y_f1", 32'({s_hcount, s_vcount, s_y}), 32'({11'd5, 11'd3, 8'h0A}));
            if (n == 369) check("s_y_f2", 32'({s_hcount, s_vcount, s_y}), 32'({11'd5, 11'd3, 8'h8A}));
            if (n == 657) check("s_y_f3", 32'({s_hcount, s_vcount, s_y}), 32'({11'd5, 11'd3, 8'h0A}));
            s_swap_req = ((n + 1) >= 100 && (n + 1) <= 288) || (n + 1) >= 400;
        end
        check("s_fb_seq", 32'(fb_err), 32'd0);
        check("s_ack_cnt", 32'(ack_cnt), 32'd3);
        check("s_ack_pos", 32'(ack_bad), 32'd0);
        check("s_fs_cnt", 32'(fs_cnt), 32'd4);
        check("s_fs_first", 32'(fs_first), 32'd4);
        check("s_fs_period", 32'(fs_second - fs_first), 32'd288);
        check("s_de_cnt", 32'(sde_cnt), 32'd128);
        check("s_hs_cnt", 32'(shs_cnt), 32'd36);
        check("s_vs_cnt", 32'(svs_cnt), 32'd48);
        check("s_vs_first", 32'(svs_first), 32'd9);
        check("s_max_addr", 32'(max_addr), 32'd31);
        check("s_addr_idle", 32'(addr_bad), 32'd0);

        s_swap_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            if (s_hcount == 11'd10 && s_vcount == 11'd5) found = 1'b1;
            else step(1);
        end
        check("s_mid_found", 32'(found), 32'd1);
        check("s_pre_rst_fb", 32'(s_fb_sel), 32'd1);
        s_rst = 1'b0;
        step(2);
        check("s_rst_flags", 32'({s_de, s_frame_start, s_y, s_fb_sel, s_swap_ack, s_rd_en}), 32'd0);
        check("s_rst_cnt", 32'({s_hcount, s_vcount, s_rd_addr}), 32'd0);
        check("s_rst_sync", 32'({s_hsync, s_vsync}), 32'd3);
        s_rst = 1'b1;
        step(3);
        check("s_n3_dark", 32'({s_de, s_frame_start}), 32'd0);
        step(1);
        check("s_restart", 32'({s_de, s_frame_start, s_hcount, s_vcount}), {8'd0, 1'b1, 1'b1, 22'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
